button_bank: RTL and testbench

BUTTON_BANK -- requirements
Module: button_bank

---
 rtl/button_bank.sv | 108 ++++++++++
 tb/tb_button_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// button_bank: debounced button bank with press/release/long-press events; auto-repeat is built only when BUTTON_BANK_REPEAT_EN is defined
module button_bank #(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 20000,
  parameter int LONG_CYCLES   = 1000000,
  parameter int REPEAT_CYCLES = 200000
) (
  input  logic             clk_1MHz,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             any_event
);
  localparam int DW = $clog2(DB_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  if (N_BTN < 1 || N_BTN > 16 || DB_CYCLES < 1 || LONG_CYCLES <= DB_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("button_bank: illegal parameter set");
  end
  logic [N_BTN-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
  logic [N_BTN-1:0] long_q, long_d, repeat_q, repeat_d;
  logic             any_event_q, any_event_d;
  assign any_event_d   = |(press_d | release_d | long_d | repeat_d);
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign any_event     = any_event_q;
  // registered outputs, so every event and its any_event OR leave on the same edge
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      repeat_q    <= '0;
      any_event_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      any_event_q <= any_event_d;
    end
  end
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] db_q, db_d;
    logic [HW-1:0] hold_q, hold_d;
    state_t        state_q, state_d;
    logic          mis, flip, long_hit;
    // debounce: count consecutive mismatch cycles and flip the level at the end of the window; hold timing follows the FSM
    always_comb begin
      sync_d   = {sync_q[0], btn_in[i]};
      mis      = sync_q[1] ^ level_q[i];
      flip     = mis && db_q == DB_LAST;
      db_d     = (mis && !flip) ? db_q + 1'b1 : '0;
      long_hit = state_q == HELD && !flip && hold_q == HOLD_LAST;
      hold_d   = (state_q == HELD && !flip && !long_hit) ? hold_q + 1'b1 : '0;
      state_d  = flip ? (level_q[i] ? IDLE : HELD) : long_hit ? LONG : state_q;
    end
    assign level_d[i]   = level_q[i] ^ flip;
    assign press_d[i]   = flip & ~level_q[i];
    assign release_d[i] = flip & level_q[i];
    assign long_d[i]    = long_hit;
    // per-channel synchroniser, debounce counter, hold counter and FSM state
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        db_q    <= '0;
        hold_q  <= '0;
        state_q <= IDLE;
      end else begin
        sync_q  <= sync_d;
        db_q    <= db_d;
        hold_q  <= hold_d;
        state_q <= state_d;
      end
    end
`ifdef BUTTON_BANK_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_hit;
    // repeat period counter runs only in LONG and wraps on each repeat; a release in the same cycle suppresses the pulse
    always_comb begin
      rep_hit = state_q == LONG && !flip && rep_q == REP_LAST;
      rep_d   = (state_q == LONG && !flip && !rep_hit) ? rep_q + 1'b1 : '0;
    end
    assign repeat_d[i] = rep_hit;
    // repeat counter register
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) rep_q <= '0;
      else rep_q <= rep_d;
    end
`else
    assign repeat_d[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank: randomized and directed checks of button_bank against a timestamp-based event model
module tb_button_bank;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int LC = 20;
  localparam int RC = 5;
  logic         clk_1MHz = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic         any_event;
  int checks = 0;
  int errors = 0;
  button_bank #(.N_BTN(N), .DB_CYCLES(DB), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)) dut (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .any_event(any_event)
  );
  always #5 clk_1MHz = ~clk_1MHz;
  task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk_1MHz);
    #1;
  endtask
  bit [N-1:0] e_lvl, e_press, e_rel, e_long, e_rep;
  bit [N-1:0] hist[$];
  bit [N-1:0] held;
  int run[N];
  int pt[N];
  int cyc = 0;
  // reference: sync value is the input seen two edges ago; level flips after DB consecutive disagreeing cycles; long/repeat are timestamps from the press
  initial forever begin
    @(posedge clk_1MHz);
    cyc++;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    e_rep   = '0;
    if (!rst_n) begin
      hist.delete();
      e_lvl = '0;
      held  = '0;
      foreach (run[c]) run[c] = 0;
    end else begin
      bit [N-1:0] sy;
      hist.push_front(btn_in);
      if (hist.size() > 3) void'(hist.pop_back());
      sy = hist.size() == 3 ? hist[2] : '0;
      for (int c = 0; c < N; c++) begin
        if (sy[c] != e_lvl[c]) begin
          run[c]++;
          if (run[c] == DB) begin
            run[c] = 0;
            e_lvl[c] = ~e_lvl[c];
            if (e_lvl[c]) begin
              e_press[c] = 1'b1;
              held[c] = 1'b1;
              pt[c] = cyc;
            end else begin
              e_rel[c] = 1'b1;
              held[c] = 1'b0;
            end
          end
        end else run[c] = 0;
        if (held[c] && !e_press[c]) begin
          int d;
          d = cyc - pt[c];
          if (d == LC) e_long[c] = 1'b1;
`ifdef BUTTON_BANK_REPEAT_EN
          if (d > LC && (d - LC) % RC == 0) e_rep[c] = 1'b1;
`endif
        end
      end
    end
  end
  // every cycle compare all outputs with the model (all zero while reset is held)
  initial forever begin
    @(negedge clk_1MHz);
    chk("level",   btn_level,     rst_n ? e_lvl   : '0);
    chk("press",   press_pulse,   rst_n ? e_press : '0);
    chk("release", release_pulse, rst_n ? e_rel   : '0);
    chk("long",    long_pulse,    rst_n ? e_long  : '0);
    chk("repeat",  repeat_pulse,  rst_n ? e_rep   : '0);
    chk("any",     {3'b000, any_event}, {3'b000, rst_n && |(e_press | e_rel | e_long | e_rep)});
  end
  initial begin
    tick(3);
    chk("reset_level", btn_level, '0);
    chk("reset_any", {3'b000, any_event}, '0);
    rst_n = 1'b1;
    tick(3);
    btn_in = 4'b0001;
    tick(5);
    chk("p0_early", press_pulse, '0);
    tick(1);
    chk("p0_press", press_pulse, 4'b0001);
    chk("p0_level", btn_level, 4'b0001);
    chk("p0_any", {3'b000, any_event}, 4'b0001);
    tick(1);
    chk("p0_one_cycle", press_pulse, '0);
    btn_in = '0;
    tick(12);
    btn_in = 4'b0010;
    tick(3);
    btn_in = '0;
    tick(8);
    chk("glitch_level", btn_level, '0);
    btn_in = 4'b0100;
    tick(6);
    chk("p2_press", press_pulse, 4'b0100);
    tick(20);
    chk("p2_long", long_pulse, 4'b0100);
    tick(5);
`ifdef BUTTON_BANK_REPEAT_EN
    chk("p2_rep1", repeat_pulse, 4'b0100);
`else
    chk("p2_rep1", repeat_pulse, '0);
`endif
    tick(15);
    btn_in = '0;
    tick(12);
    btn_in = 4'b1000;
    tick(6);
    chk("p3_press", press_pulse, 4'b1000);
    tick(12);
    btn_in = '0;
    tick(5);
    chk("p3_rel_early", release_pulse, '0);
    tick(1);
    chk("p3_release", release_pulse, 4'b1000);
    chk("p3_level", btn_level, '0);
    tick(10);
    btn_in = 4'b1001;
    tick(6);
    chk("dual_press", press_pulse, 4'b1001);
    btn_in = '0;
    tick(12);
    btn_in = 4'b0001;
    tick(6);
    chk("r_press", press_pulse, 4'b0001);
    tick(15);
    rst_n = 1'b0;
    #1;
    chk("r_level", btn_level, '0);
    chk("r_release", release_pulse, '0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("r_early", press_pulse, '0);
    tick(1);
    chk("r_repress", press_pulse, 4'b0001);
    for (int k = 0; k < 250; k++) begin
      btn_in = btn_in ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(20, 45));
      else tick($urandom_range(1, 8));
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    btn_in = '0;
    tick(12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
